// File: rtl/if_stage_if.sv
// if_stage_if: bundle of the fetch stage's external handshakes.
//   redirect_valid/redirect_pc : branch/jump redirect from a later stage
//   imem_req/imem_addr         : instruction-memory request (one cycle per request)
//   imem_rvalid/imem_rdata     : instruction-memory response
//   if_valid/if_pc/if_instr    : fetched instruction presented to decode
//   id_ready                   : decode accepts the presented instruction
// master = the fetch stage, slave = its environment (memory + pipeline).
interface if_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a single outstanding memory request.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : if_stage_if.master (redirect, imem request/response, decode output)
// Loop: ISSUE (request pc) -> WAIT (response) -> HOLD (present to decode)
// -> ISSUE at pc+4. DROP absorbs a response whose request was made stale by
// a redirect, so the memory never has more than one request in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  if_stage_if.master   bus
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;

  assign bus.imem_req  = (state == ISSUE);
  assign bus.imem_addr = (state == ISSUE) ? pc : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ISSUE;
      pc           <= RESET_PC;
      bus.if_valid <= 1'b0;
      bus.if_pc    <= '0;
      bus.if_instr <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything; a coinciding decode handshake is
      // considered consumed, so pc takes the target rather than pc+4.
      pc           <= {bus.redirect_pc[31:2], 2'b00};
      bus.if_valid <= 1'b0;
      unique case (state)
        ISSUE:   state <= DROP;   // request already sent, its reply must be eaten
        WAIT:    state <= bus.imem_rvalid ? ISSUE : DROP;
        HOLD:    state <= ISSUE;
        DROP:    state <= DROP;
        default: state <= ISSUE;
      endcase
    end else begin
      unique case (state)
        ISSUE: state <= WAIT;
        WAIT: begin
          if (bus.imem_rvalid) begin
            bus.if_instr <= bus.imem_rdata;
            bus.if_pc    <= pc;
            bus.if_valid <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (bus.id_ready) begin
            bus.if_valid <= 1'b0;
            pc           <= pc + 32'd4;
            state        <= ISSUE;
          end
        end
        DROP: begin
          if (bus.imem_rvalid) begin
            state <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic clk;
  logic rst0, rst1;
  int   tests, fails;

  if_stage_if b0();
  if_stage_if b1();

  if_stage #(.RESET_PC(32'h0000_0000)) u0 (.clk(clk), .rst(rst0), .bus(b0));
  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (.clk(clk), .rst(rst1), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        mv;
    logic [31:0] md;
    logic        idr;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[34];

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic mv,
                              logic [31:0] md, logic idr, logic req,
                              logic [31:0] addr, logic v, logic [31:0] pc,
                              logic [31:0] instr);
    vec_t t;
    t.rst = r; t.rv = rv; t.rpc = rpc; t.mv = mv; t.md = md; t.idr = idr;
    t.req = req; t.addr = addr; t.v = v; t.pc = pc; t.instr = instr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: a request is either about to be issued,
  // outstanding (possibly stale after a redirect), or its instruction is
  // being presented to decode.
  logic [31:0] m_pc, m_ifpc, m_instr;
  logic        m_need, m_pend, m_stale, m_pres;

  // Memory: single slot, latency chosen per request.
  logic        mem_busy;
  int unsigned mem_cnt;
  logic [31:0] mem_data;

  task automatic model_step();
    logic resp;
    if (rst0) begin
      m_pc = 32'h0; m_need = 1'b1; m_pend = 1'b0; m_stale = 1'b0;
      m_pres = 1'b0; m_ifpc = '0; m_instr = '0;
    end else begin
      resp = m_pend && b0.imem_rvalid;
      if (b0.redirect_valid) begin
        if (m_need) begin
          m_need = 1'b0; m_pend = 1'b1; m_stale = 1'b1;
        end else if (m_pend && !m_stale) begin
          if (resp) begin m_pend = 1'b0; m_need = 1'b1; end
          else m_stale = 1'b1;
        end else if (m_pres) begin
          m_need = 1'b1;
        end
        m_pres = 1'b0;
        m_pc   = {b0.redirect_pc[31:2], 2'b00};
      end else if (m_need) begin
        m_need = 1'b0; m_pend = 1'b1; m_stale = 1'b0;
      end else if (resp) begin
        m_pend = 1'b0;
        if (m_stale) m_need = 1'b1;
        else begin m_pres = 1'b1; m_ifpc = m_pc; m_instr = b0.imem_rdata; end
      end else if (m_pres && b0.id_ready) begin
        m_pres = 1'b0; m_pc = m_pc + 32'd4; m_need = 1'b1;
      end
    end
  endtask

  task automatic mem_step(input logic req_seen);
    if (rst0) begin
      mem_busy = 1'b0;
    end else begin
      if (mem_busy && b0.imem_rvalid) mem_busy = 1'b0;
      else if (mem_busy && mem_cnt > 1) mem_cnt--;
      if (req_seen) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(1, 3);
        mem_data = $urandom;
      end
    end
  endtask

  initial begin
    logic req_seen;
    logic r;
    tests = 0; fails = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    b0.redirect_valid = 1'b0; b0.redirect_pc = '0; b0.imem_rvalid = 1'b0;
    b0.imem_rdata = '0; b0.id_ready = 1'b0;
    b1.redirect_valid = 1'b0; b1.redirect_pc = '0; b1.imem_rvalid = 1'b0;
    b1.imem_rdata = '0; b1.id_ready = 1'b0;

    // in: rst rv rpc mv md idr | exp: req addr v pc instr
    tbl[0]  = mk(0,0,0,0,0,1,                     1,32'h0,0,32'h0,32'h0);
    tbl[1]  = mk(0,0,0,1,32'h0000_0013,1,         0,32'h0,0,32'h0,32'h0);
    tbl[2]  = mk(0,0,0,0,0,1,                     0,32'h0,1,32'h0,32'h0000_0013);
    tbl[3]  = mk(0,0,0,0,0,1,                     1,32'h4,0,32'h0,32'h0000_0013);
    tbl[4]  = mk(0,0,0,1,32'h0010_0093,1,         0,32'h0,0,32'h0,32'h0000_0013);
    tbl[5]  = mk(0,0,0,0,0,1,                     0,32'h0,1,32'h4,32'h0010_0093);
    tbl[6]  = mk(0,0,0,0,0,1,                     1,32'h8,0,32'h4,32'h0010_0093);
    tbl[7]  = mk(0,0,0,1,32'h0050_0093,0,         0,32'h0,0,32'h4,32'h0010_0093);
    for (int i = 8; i < 13; i++)
      tbl[i] = mk(0,0,0,0,0,0,                    0,32'h0,1,32'h8,32'h0050_0093);
    tbl[13] = mk(0,0,0,0,0,1,                     0,32'h0,1,32'h8,32'h0050_0093);
    tbl[14] = mk(0,0,0,0,0,0,                     1,32'hC,0,32'h8,32'h0050_0093);
    tbl[15] = mk(0,1,32'h0000_0102,0,0,0,         0,32'h0,0,32'h8,32'h0050_0093);
    tbl[16] = mk(0,0,0,0,0,0,                     0,32'h0,0,32'h8,32'h0050_0093);
    tbl[17] = mk(0,0,0,1,32'hDEAD_BEEF,0,         0,32'h0,0,32'h8,32'h0050_0093);
    tbl[18] = mk(0,0,0,0,0,0,                     1,32'h100,0,32'h8,32'h0050_0093);
    tbl[19] = mk(0,0,0,1,32'h1234_5678,0,         0,32'h0,0,32'h8,32'h0050_0093);
    tbl[20] = mk(0,1,32'h0000_0200,0,0,1,         0,32'h0,1,32'h100,32'h1234_5678);
    tbl[21] = mk(0,0,0,0,0,0,                     1,32'h200,0,32'h100,32'h1234_5678);
    tbl[22] = mk(0,1,32'h0000_0303,0,0,0,         0,32'h0,0,32'h100,32'h1234_5678);
    tbl[21].rv = 1'b1; tbl[21].rpc = 32'h0000_0303;
    tbl[22] = mk(0,0,0,1,32'hBAD0_0001,0,         0,32'h0,0,32'h100,32'h1234_5678);
    tbl[23] = mk(0,0,0,0,0,0,                     1,32'h300,0,32'h100,32'h1234_5678);
    tbl[24] = mk(0,1,32'h0000_0040,1,32'hBAD0_0002,0, 0,32'h0,0,32'h100,32'h1234_5678);
    tbl[25] = mk(0,0,0,0,0,0,                     1,32'h40,0,32'h100,32'h1234_5678);
    tbl[26] = mk(0,0,0,0,0,1,                     0,32'h0,0,32'h100,32'h1234_5678);
    tbl[27] = mk(0,0,0,1,32'hCAFE_F00D,0,         0,32'h0,0,32'h100,32'h1234_5678);
    tbl[28] = mk(0,0,0,0,0,1,                     0,32'h0,1,32'h40,32'hCAFE_F00D);
    tbl[29] = mk(0,0,0,0,0,0,                     1,32'h44,0,32'h40,32'hCAFE_F00D);
    tbl[30] = mk(0,0,0,0,0,0,                     0,32'h0,0,32'h40,32'hCAFE_F00D);
    tbl[31] = mk(1,1,32'h0000_0500,1,32'hBAD0_0003,1, 0,32'h0,0,32'h40,32'hCAFE_F00D);
    tbl[32] = mk(0,0,0,0,0,0,                     1,32'h0,0,32'h0,32'h0);
    tbl[33] = mk(0,0,0,0,0,0,                     0,32'h0,0,32'h0,32'h0);

    @(posedge clk); @(posedge clk); #1;
    rst0 = 1'b0;

    for (int i = 0; i < 34; i++) begin
      rst0 = tbl[i].rst;
      b0.redirect_valid = tbl[i].rv; b0.redirect_pc = tbl[i].rpc;
      b0.imem_rvalid = tbl[i].mv;    b0.imem_rdata = tbl[i].md;
      b0.id_ready = tbl[i].idr;
      @(negedge clk);
      chk($sformatf("vec%0d imem_req", i),  {31'b0, b0.imem_req}, {31'b0, tbl[i].req});
      chk($sformatf("vec%0d imem_addr", i), b0.imem_addr, tbl[i].addr);
      chk($sformatf("vec%0d if_valid", i),  {31'b0, b0.if_valid}, {31'b0, tbl[i].v});
      chk($sformatf("vec%0d if_pc", i),     b0.if_pc, tbl[i].pc);
      chk($sformatf("vec%0d if_instr", i),  b0.if_instr, tbl[i].instr);
      @(posedge clk); #1;
    end

    // Wrap-around from the top of the address space.
    rst1 = 1'b0;
    @(negedge clk);
    chk("wrap first req", {31'b0, b1.imem_req}, 32'd1);
    chk("wrap first addr", b1.imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    b1.imem_rvalid = 1'b1; b1.imem_rdata = 32'h0000_0013;
    @(posedge clk); #1;
    b1.imem_rvalid = 1'b0; b1.id_ready = 1'b1;
    @(negedge clk);
    chk("wrap if_valid", {31'b0, b1.if_valid}, 32'd1);
    chk("wrap if_pc", b1.if_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    b1.id_ready = 1'b0;
    @(negedge clk);
    chk("wrap next req", {31'b0, b1.imem_req}, 32'd1);
    chk("wrap next addr", b1.imem_addr, 32'h0000_0000);

    // Randomised run against the reference model.
    @(posedge clk); #1;
    rst0 = 1'b1; b0.redirect_valid = 1'b0; b0.imem_rvalid = 1'b0;
    @(posedge clk);
    model_step();
    mem_busy = 1'b0; mem_cnt = 0; mem_data = '0;
    #1;
    for (int n = 0; n < 3000; n++) begin
      rst0 = ($urandom_range(0, 199) == 0);
      b0.id_ready    = 1'($urandom_range(0, 1));
      b0.imem_rvalid = mem_busy && (mem_cnt == 1);
      b0.imem_rdata  = b0.imem_rvalid ? mem_data : $urandom;
      // A redirect landing on the stale reply itself would strand the fetch
      // loop; the pipeline never does that, so it is not generated.
      r = ($urandom_range(0, 7) == 0) && !(m_stale && m_pend && b0.imem_rvalid);
      b0.redirect_valid = r;
      b0.redirect_pc    = $urandom;
      @(negedge clk);
      chk("rnd imem_req",  {31'b0, b0.imem_req}, {31'b0, m_need});
      chk("rnd imem_addr", b0.imem_addr, m_need ? m_pc : 32'h0);
      chk("rnd if_valid",  {31'b0, b0.if_valid}, {31'b0, m_pres});
      chk("rnd if_pc",     b0.if_pc, m_ifpc);
      chk("rnd if_instr",  b0.if_instr, m_instr);
      req_seen = b0.imem_req;
      @(posedge clk);
      model_step();
      mem_step(req_seen);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: address of the first fetch after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 redirect_valid  input  1  branch/jump redirect from a later stage.
REQ-005 redirect_pc  input  32  redirect target address.
REQ-006 imem_req  output  1  instruction-memory request strobe, one cycle per request.
REQ-007 imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-008 imem_rvalid  input  1  instruction-memory response strobe.
REQ-009 imem_rdata  input  32  instruction word, valid while imem_rvalid=1.
REQ-010 if_valid  output  1  if_pc/if_instr hold a fetched instruction for decode.
REQ-011 if_pc  output  32  address of if_instr.
REQ-012 if_instr  output  32  fetched instruction word fed to decode.
REQ-013 id_ready  input  1  decode accepts the instruction this cycle.

Function
REQ-014 The block SHALL hold one 32-bit pc register and a 4-state FSM: ISSUE, WAIT, HOLD, DROP.
REQ-015 imem_req SHALL be 1 only in ISSUE, with imem_addr = pc; imem_addr SHALL be 0 outside ISSUE.
REQ-016 The block SHALL have at most one outstanding memory request.
REQ-017 ISSUE SHALL go to WAIT after one cycle, unless redirect_valid=1 that cycle (REQ-022).
REQ-018 In WAIT with imem_rvalid=1, the block SHALL register if_instr=imem_rdata, if_pc=pc and if_valid=1, then go to HOLD.
REQ-019 In HOLD, if_valid/if_pc/if_instr SHALL stay stable until id_ready=1.
REQ-020 In HOLD with id_ready=1, the block SHALL clear if_valid, set pc to pc+4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0) and go to ISSUE.
REQ-021 Minimum fetch loop SHALL be ISSUE->WAIT->HOLD->ISSUE with 1-cycle memory latency: one instruction per 3 cycles.
REQ-022 redirect_valid=1 SHALL take priority over every other event in every state.
REQ-023 On redirect, the block SHALL set pc to {redirect_pc[31:2],2'b00}, clearing redirect_pc[1:0].
REQ-024 On redirect, the block SHALL set if_valid to 0 next cycle.
REQ-025 On redirect, the next state SHALL depend on the current state:
- ISSUE or WAIT with no imem_rvalid that cycle: go to DROP.
- WAIT with imem_rvalid that cycle: discard the response, go to ISSUE.
- HOLD: go to ISSUE.
- DROP: stay in DROP.
REQ-026 A HOLD id_ready handshake coinciding with a redirect SHALL be treated as consumed, with pc taking the redirect target, not pc+4.
REQ-027 In DROP, imem_rvalid=1 SHALL be discarded (outputs unchanged, if_valid=0), then the state SHALL go to ISSUE.
REQ-028 imem_rvalid in ISSUE or HOLD SHALL be ignored; the memory never produces it there.
REQ-029 id_ready SHALL be ignored when if_valid=0.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL set pc=RESET_PC, state=ISSUE and if_valid=0, and clear if_pc and if_instr to 0.
REQ-031 rst SHALL override redirect_valid and imem_rvalid.
REQ-032 A response to a request in flight when reset hits SHALL be dropped: the memory is reset together with the block.
REQ-033 In the first cycle after rst falls, the block SHALL drive imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-034 Reset release, 1-cycle memory, id_ready=1 -> requests to 0x0, 0x4, 0x8 every 3 cycles; if_pc matches each; if_instr equals the returned word.
REQ-035 Back-pressure: id_ready=0 for 5 cycles in HOLD with if_instr=0x00500093 -> outputs stable, no imem_req; id_ready=1 -> next request at if_pc+4.
REQ-036 Redirect in WAIT to 0x0000_0102 (3-cycle memory latency) -> pending response dropped, if_valid stays 0, next imem_addr=0x0000_0100.
REQ-037 Redirect in HOLD together with id_ready=1 to 0x200 -> next imem_addr=0x200, not if_pc+4.
REQ-038 Wrap-around: RESET_PC=0xFFFF_FFFC, instruction accepted -> next imem_addr=0x0000_0000.
REQ-039 rst asserted in WAIT, with the memory also reset -> if_valid=0; first request after release goes to RESET_PC.
